// File: rtl/pwm_fade_ctrl_pkg.sv
// rtl/pwm_fade_ctrl_pkg.sv - shared types and duty clamp helper for the fade engine
package pwm_pkg;

   typedef enum logic {FADE_IDLE = 1'b0, FADE_RAMP = 1'b1} fade_state_t;

   // Saturates a requested duty to 2**r (100% duty at resolution r).
   function automatic logic [31:0] clamp_duty(input logic [31:0] val, input int unsigned r);
      logic [31:0] full;
      full = 32'd1 << r;
      return (val > full) ? full : val;
   endfunction

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// rtl/pwm_fade_ctrl_if.sv - target-duty offer bundle between command decoder and fade engine
interface pwm_fade_ctrl_if #(
   parameter int R      = 8,
   parameter int STEP_W = 16
);
   logic [R:0]        tgt_duty;
   logic              tgt_valid;
   logic              tgt_ready;
   logic [STEP_W-1:0] step_dvsr;
   logic [R-1:0]      step_size;

   modport master (output tgt_duty, tgt_valid, step_dvsr, step_size, input tgt_ready);
   modport slave  (input tgt_duty, tgt_valid, step_dvsr, step_size, output tgt_ready);
endinterface

// File: rtl/pwm_fade_ctrl_prescaler.sv
// rtl/pwm_fade_ctrl_prescaler.sv - per-step clock divider; tick on the last count of each period
module fade_prescaler #(
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [STEP_W-1:0] dvsr,
   output logic              tick
);
   logic [STEP_W-1:0] cnt;

   assign tick = en & (cnt == dvsr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == dvsr) ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - duty ramp engine; PWM_FADE_BREATHE_EN adds the breathe auto-cycling port
module pwm_fade_ctrl
   import pwm_pkg::*;
#(
   parameter int R      = 8,
   parameter int STEP_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   pwm_fade_ctrl_if.slave tgt,
`ifdef PWM_FADE_BREATHE_EN
   input  logic          breathe,
`endif
   output logic [R:0]    duty_out,
   output logic          busy,
   output logic          done
);
   localparam int W = R + 2;
   localparam int D = R + 1;
   localparam logic [0:0] ST_IDLE = 1'(FADE_IDLE);
   localparam logic [0:0] ST_RAMP = 1'(FADE_RAMP);

   logic [0:0]        state;
   logic [R:0]        target_q;
   logic [STEP_W-1:0] dvsr_q;
   logic [R-1:0]      size_q;
   logic              transfer, auto_start, tick;
   logic [R:0]        req_clamped;
   logic [W-1:0]      duty_w, tgt_w, step_w, diff_w, up_w, dn_w;

   assign tgt.tgt_ready = (state == ST_IDLE);
   assign busy          = (state == ST_RAMP);
   assign transfer      = tgt.tgt_valid & tgt.tgt_ready;
   assign req_clamped   = D'(clamp_duty(32'(tgt.tgt_duty), R));

`ifdef PWM_FADE_BREATHE_EN
   logic [R:0] peak_q, auto_tgt;
   // Bounce between the last handshaken peak and zero while breathe is held.
   assign auto_tgt   = (duty_out == peak_q) ? '0 : peak_q;
   assign auto_start = (state == ST_IDLE) & breathe & ~tgt.tgt_valid & (auto_tgt != duty_out);
`else
   assign auto_start = 1'b0;
`endif

   // Extra headroom bit keeps up/down steps from wrapping past 0 or 2**R.
   assign duty_w = W'(duty_out);
   assign tgt_w  = W'(target_q);
   assign step_w = W'(size_q);
   assign diff_w = (tgt_w >= duty_w) ? (tgt_w - duty_w) : (duty_w - tgt_w);
   assign up_w   = duty_w + step_w;
   assign dn_w   = duty_w - step_w;

   fade_prescaler #(.STEP_W(STEP_W)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (transfer | auto_start),
      .en    (state == ST_RAMP),
      .dvsr  (dvsr_q),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         duty_out <= '0;
         done     <= 1'b0;
         target_q <= '0;
         dvsr_q   <= '0;
         size_q   <= '0;
`ifdef PWM_FADE_BREATHE_EN
         peak_q   <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (transfer) begin
                  target_q <= req_clamped;
                  dvsr_q   <= tgt.step_dvsr;
                  size_q   <= (tgt.step_size == '0) ? R'(1) : tgt.step_size;
`ifdef PWM_FADE_BREATHE_EN
                  peak_q   <= req_clamped;
`endif
                  if (req_clamped == duty_out) done  <= 1'b1;
                  else                         state <= ST_RAMP;
               end
`ifdef PWM_FADE_BREATHE_EN
               else if (auto_start) begin
                  target_q <= auto_tgt;
                  state    <= ST_RAMP;
               end
`endif
            end
            default: begin
               if (tick) begin
                  if (diff_w <= step_w) begin
                     duty_out <= target_q;
                     done     <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     duty_out <= (tgt_w > duty_w) ? D'(up_w) : D'(dn_w);
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - randomized fades checked cycle by cycle against an arithmetic step model
module tb_pwm_fade_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       breathe = 1'b0;
   logic [8:0] duty_out;
   logic       busy, done;
   int         total = 0;
   int         bad = 0;
   int         cur = 0;

   pwm_fade_ctrl_if #(.R(8), .STEP_W(16)) tif ();

   pwm_fade_ctrl #(.R(8), .STEP_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tgt      (tif),
`ifdef PWM_FADE_BREATHE_EN
      .breathe  (breathe),
`endif
      .duty_out (duty_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected duty after k ticks comes from a list of end points built with plain arithmetic.
   task automatic run_ramp(input int start, input int tc, input int se, input int per,
                           input bit post, input bit hold, input int hold_duty, input bit drop_br);
      int q[$];
      int d, diff, k, n_last, exp_d;
      d = start;
      while (d != tc) begin
         diff = (tc > d) ? tc - d : d - tc;
         d = (diff <= se) ? tc : ((tc > d) ? d + se : d - se);
         q.push_back(d);
      end
      @(posedge clk);
      #1;
      if (hold) tif.tgt_duty = 9'(hold_duty);
      else tif.tgt_valid = 1'b0;
      if (drop_br) breathe = 1'b0;
      if (!hold) begin
         tif.step_dvsr = 16'($urandom);
         tif.step_size = 8'($urandom);
      end
      if (q.size() == 0) begin
         @(negedge clk);
         check("eq_done", int'(done), 1);
         check("eq_busy", int'(busy), 0);
         check("eq_duty", int'(duty_out), start);
         if (post) begin
            @(negedge clk);
            check("eq_done_clr", int'(done), 0);
         end
      end else begin
         n_last = q.size() * per;
         for (int n = 0; n <= n_last; n++) begin
            @(negedge clk);
            k = n / per;
            exp_d = (k == 0) ? start : q[k-1];
            check("duty", int'(duty_out), exp_d);
            check("busy", int'(busy), (n == n_last) ? 0 : 1);
            check("done", int'(done), (n == n_last) ? 1 : 0);
            check("ready", int'(tif.tgt_ready), (n == n_last) ? 1 : 0);
         end
         if (post) begin
            @(negedge clk);
            check("done_clr", int'(done), 0);
            check("duty_hold", int'(duty_out), tc);
            check("busy_idle", int'(busy), 0);
         end
      end
   endtask

   task automatic do_fade(input int t, input int s, input int v,
                          input bit post, input bit hold, input int hold_duty);
      int tc, se;
      tif.tgt_duty  = 9'(t);
      tif.step_size = 8'(s);
      tif.step_dvsr = 16'(v);
      tif.tgt_valid = 1'b1;
      check("ready_in", int'(tif.tgt_ready), 1);
      tc = (t > 256) ? 256 : t;
      se = (s == 0) ? 1 : s;
      run_ramp(cur, tc, se, v + 1, post, hold, hold_duty, 1'b0);
      cur = tc;
   endtask

   initial begin
      int t, s, v;
      tif.tgt_duty  = '0;
      tif.tgt_valid = 1'b0;
      tif.step_dvsr = '0;
      tif.step_size = '0;
      #12;
      check("rst_duty", int'(duty_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(tif.tgt_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_fade(256, 64, 3, 1, 0, 0);
      do_fade(0, 100, 0, 1, 0, 0);
      do_fade(300, 128, 0, 1, 0, 0);
      do_fade(256, 5, 3, 1, 0, 0);
      do_fade(200, 50, 1, 0, 1, 10);
      do_fade(10, 60, 2, 1, 0, 0);
      do_fade(0, 0, 0, 1, 0, 0);

      for (int i = 0; i < 20; i++) begin
         t = $urandom_range(0, 300);
         s = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(8, 255);
         v = $urandom_range(0, 4);
         do_fade(t, s, v, 1, 0, 0);
      end

      tif.tgt_duty  = 9'd200;
      tif.step_size = 8'd10;
      tif.step_dvsr = 16'd2;
      tif.tgt_valid = 1'b1;
      @(posedge clk);
      #1 tif.tgt_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_duty", int'(duty_out), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_done", int'(done), 0);
      check("arst_ready", int'(tif.tgt_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      cur = 0;
      @(negedge clk);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_duty", int'(duty_out), 0);
      do_fade(40, 16, 1, 1, 0, 0);

`ifdef PWM_FADE_BREATHE_EN
      do_fade(0, 8, 0, 1, 0, 0);
      do_fade(128, 32, 1, 0, 0, 0);
      breathe = 1'b1;
      run_ramp(128, 0, 32, 2, 0, 0, 0, 1'b0);
      run_ramp(0, 128, 32, 2, 0, 0, 0, 1'b0);
      run_ramp(128, 0, 32, 2, 0, 0, 0, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("br_stop_busy", int'(busy), 0);
         check("br_stop_duty", int'(duty_out), 0);
      end
      cur = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
